// File: rtl/rf_acc_bank_pkg.sv
// Shared types and constants for the accumulator register bank.
// Holds the context-sequencer state encoding, the accumulator index and
// the default bank geometry used by rf_acc_bank and rf_ctx_seq.
package rf_pkg;

   typedef enum logic [1:0] {
      CTX_IDLE    = 2'd0,
      CTX_SAVE    = 2'd1,
      CTX_RESTORE = 2'd2,
      CTX_DONE    = 2'd3
   } ctx_state_e;

   localparam int ACC_IDX      = 0;
   localparam int DEF_DATA_W   = 8;
   localparam int DEF_NUM_REGS = 8;

endpackage

// File: rtl/rf_acc_bank_if.sv
// Bus bundle between the datapath and the accumulator register bank.
// master: datapath side (drives write/read selects, context requests).
// slave : register bank side (drives read data, accumulator/pair views, busy/done).
interface rf_acc_bank_if #(
   parameter int DATA_W = 8,
   parameter int SEL_W  = 3
);
   logic [DATA_W-1:0]   Data_in;
   logic [SEL_W-1:0]    Wr_sel;
   logic                RF_we;
   logic [DATA_W-1:0]   Acc_in;
   logic                Acc_we;
   logic [2*DATA_W-1:0] Pair_in;
   logic                Pair_we;
   logic [SEL_W-1:0]    Rd_sel_a;
   logic [SEL_W-1:0]    Rd_sel_b;
   logic [DATA_W-1:0]   Data_out_a;
   logic [DATA_W-1:0]   Data_out_b;
   logic [DATA_W-1:0]   Acc_out;
   logic [2*DATA_W-1:0] Pair_out;
   logic                Ctx_save;
   logic                Ctx_restore;
   logic                Ctx_busy;
   logic                Ctx_done;

   modport master (
      output Data_in, Wr_sel, RF_we, Acc_in, Acc_we, Pair_in, Pair_we,
             Rd_sel_a, Rd_sel_b, Ctx_save, Ctx_restore,
      input  Data_out_a, Data_out_b, Acc_out, Pair_out, Ctx_busy, Ctx_done
   );

   modport slave (
      input  Data_in, Wr_sel, RF_we, Acc_in, Acc_we, Pair_in, Pair_we,
             Rd_sel_a, Rd_sel_b, Ctx_save, Ctx_restore,
      output Data_out_a, Data_out_b, Acc_out, Pair_out, Ctx_busy, Ctx_done
   );

endinterface

// File: rtl/rf_acc_bank_ctx_seq.sv
// Context save/restore sequencer: walks idx 0..NUM_REGS-1, one register per cycle.
// Ports: clk/rst_n, save_req/restore_req in; copy_stb, copy_restore (direction),
// idx, busy, done (one-cycle pulse in DONE) out. Requests are ignored while busy.
module rf_ctx_seq
   import rf_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int SEL_W    = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             save_req,
   input  logic             restore_req,
   output logic             copy_stb,
   output logic             copy_restore,
   output logic [SEL_W-1:0] idx,
   output logic             busy,
   output logic             done
);

   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

   ctx_state_e       state_q, state_d;
   logic [SEL_W-1:0] idx_q, idx_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CTX_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      copy_stb     = 1'b0;
      copy_restore = 1'b0;
      busy         = 1'b1;
      done         = 1'b0;
      case (state_q)
         CTX_IDLE: begin
            busy  = 1'b0;
            idx_d = '0;
            // save takes precedence; a simultaneous restore is simply dropped
            if (save_req)         state_d = CTX_SAVE;
            else if (restore_req) state_d = CTX_RESTORE;
         end
         CTX_SAVE, CTX_RESTORE: begin
            copy_stb     = 1'b1;
            copy_restore = (state_q == CTX_RESTORE);
            idx_d        = idx_q + SEL_W'(1);
            if (idx_q == LAST_IDX) state_d = CTX_DONE;
         end
         CTX_DONE: begin
            done    = 1'b1;
            state_d = CTX_IDLE;
         end
         default: state_d = CTX_IDLE;
      endcase
   end

   assign idx = idx_q;

endmodule

// File: rtl/rf_acc_bank.sv
// Register file with accumulator at index 0, register pair view and a shadow bank.
// Ports: RF_clk, RF_rst_n (async active-low), bus (rf_acc_bank_if.slave).
// Optional macro RF_BYPASS_EN: same-cycle write data forwarded to reads (not while busy).
module rf_acc_bank
   import rf_pkg::*;
#(
   parameter int                DATA_W   = DEF_DATA_W,
   parameter int                NUM_REGS = DEF_NUM_REGS,
   parameter int                SEL_W    = 3,
   parameter int                PAIR_HI  = 5,
   parameter int                PAIR_LO  = 6,
   parameter logic [DATA_W-1:0] ACC_RST  = '0
) (
   input logic          RF_clk,
   input logic          RF_rst_n,
   rf_acc_bank_if.slave bus
);

   logic [DATA_W-1:0] live_q   [NUM_REGS];
   logic [DATA_W-1:0] shadow_q [NUM_REGS];
   logic [DATA_W-1:0] host_dat [NUM_REGS];
   logic [DATA_W-1:0] view     [NUM_REGS];
   logic [NUM_REGS-1:0] host_we;

   logic             copy_stb;
   logic             copy_restore;
   logic [SEL_W-1:0] idx;
   logic             busy;
   logic             done;
   logic [DATA_W-1:0] rd_a;
   logic [DATA_W-1:0] rd_b;

   rf_ctx_seq #(
      .NUM_REGS (NUM_REGS),
      .SEL_W    (SEL_W)
   ) u_seq (
      .clk          (RF_clk),
      .rst_n        (RF_rst_n),
      .save_req     (bus.Ctx_save),
      .restore_req  (bus.Ctx_restore),
      .copy_stb     (copy_stb),
      .copy_restore (copy_restore),
      .idx          (idx),
      .busy         (busy),
      .done         (done)
   );

   // Host write arbitration per register: pair beats general beats accumulator.
   // Everything is dropped while the sequencer owns the bank.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         host_we[i]  = 1'b0;
         host_dat[i] = live_q[i];
         if (!busy) begin
            if (bus.Pair_we && i == PAIR_HI) begin
               host_we[i]  = 1'b1;
               host_dat[i] = bus.Pair_in[2*DATA_W-1:DATA_W];
            end else if (bus.Pair_we && i == PAIR_LO) begin
               host_we[i]  = 1'b1;
               host_dat[i] = bus.Pair_in[DATA_W-1:0];
            end else if (bus.RF_we && bus.Wr_sel == SEL_W'(i)) begin
               host_we[i]  = 1'b1;
               host_dat[i] = bus.Data_in;
            end else if (bus.Acc_we && i == ACC_IDX) begin
               host_we[i]  = 1'b1;
               host_dat[i] = bus.Acc_in;
            end
         end
      end
   end

   always_ff @(posedge RF_clk or negedge RF_rst_n) begin
      if (!RF_rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            live_q[i]   <= (i == ACC_IDX) ? ACC_RST : '0;
            shadow_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            // host_we is already forced low while busy, so the two never collide
            if (host_we[i])
               live_q[i] <= host_dat[i];
            else if (copy_stb && copy_restore && idx == SEL_W'(i))
               live_q[i] <= shadow_q[i];
            if (copy_stb && !copy_restore && idx == SEL_W'(i))
               shadow_q[i] <= live_q[i];
         end
      end
   end

   // Read-side view of every register; with bypass the winning write shows through.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         view[i] = live_q[i];
`ifdef RF_BYPASS_EN
         if (host_we[i]) view[i] = host_dat[i];
`endif
      end
   end

   // Unmatched selects (index >= NUM_REGS) fall through to zero.
   always_comb begin
      rd_a = '0;
      rd_b = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (bus.Rd_sel_a == SEL_W'(i)) rd_a = view[i];
         if (bus.Rd_sel_b == SEL_W'(i)) rd_b = view[i];
      end
   end

   assign bus.Data_out_a = rd_a;
   assign bus.Data_out_b = rd_b;
   assign bus.Acc_out    = view[ACC_IDX];
   assign bus.Pair_out   = {view[PAIR_HI], view[PAIR_LO]};
   assign bus.Ctx_busy   = busy;
   assign bus.Ctx_done   = done;

endmodule

// File: tb/tb_rf_acc_bank.sv
// Directed bench for rf_acc_bank: reset, write priority, pair, save/restore,
// blocked writes while busy, reset abort and (optionally) bypass visibility.
// Inputs change 1 ns after the rising edge; outputs are sampled before the next edge.
module tb_rf_acc_bank;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;
   int   busy_cnt;
   int   done_cnt;
   int   done_at;

   rf_acc_bank_if #(.DATA_W(8), .SEL_W(3)) bus ();

   rf_acc_bank #(
      .DATA_W   (8),
      .NUM_REGS (8),
      .SEL_W    (3),
      .PAIR_HI  (5),
      .PAIR_LO  (6),
      .ACC_RST  (8'h49)
   ) dut (
      .RF_clk   (clk),
      .RF_rst_n (rst_n),
      .bus      (bus.slave)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_chk(input string tag, input int r, input logic [7:0] exp);
      bus.Rd_sel_a = 3'(r);
      bus.Rd_sel_b = 3'(r);
      #1;
      chk({tag, "_a"}, {8'h00, bus.Data_out_a}, {8'h00, exp});
      chk({tag, "_b"}, {8'h00, bus.Data_out_b}, {8'h00, exp});
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.Data_in = '0; bus.Wr_sel = '0; bus.RF_we = 1'b0;
      bus.Acc_in = '0;  bus.Acc_we = 1'b0;
      bus.Pair_in = '0; bus.Pair_we = 1'b0;
      bus.Rd_sel_a = '0; bus.Rd_sel_b = '0;
      bus.Ctx_save = 1'b0; bus.Ctx_restore = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;

      // 1: reset state
      chk("rst_acc", {8'h00, bus.Acc_out}, 16'h0049);
      chk("rst_busy", {15'd0, bus.Ctx_busy}, 16'h0000);
      chk("rst_done", {15'd0, bus.Ctx_done}, 16'h0000);
      chk("rst_pair", bus.Pair_out, 16'h0000);
      rd_chk("rst_r0", 0, 8'h49);
      for (int r = 1; r < 8; r++) rd_chk("rst_rn", r, 8'h00);

      // 2: independent general + accumulator writes, then same-register priority
      bus.RF_we = 1'b1; bus.Wr_sel = 3'd2; bus.Data_in = 8'h06;
      bus.Acc_we = 1'b1; bus.Acc_in = 8'h11;
      tick();
      bus.RF_we = 1'b0; bus.Acc_we = 1'b0;
      rd_chk("wr_r2", 2, 8'h06);
      chk("wr_acc", {8'h00, bus.Acc_out}, 16'h0011);
      bus.RF_we = 1'b1; bus.Wr_sel = 3'd0; bus.Data_in = 8'h22;
      bus.Acc_we = 1'b1; bus.Acc_in = 8'h33;
      tick();
      bus.RF_we = 1'b0; bus.Acc_we = 1'b0;
      #1;
      chk("prio_rf_over_acc", {8'h00, bus.Acc_out}, 16'h0022);

      // 3: pair write beats general write on the high byte
      bus.Pair_we = 1'b1; bus.Pair_in = 16'hBEEF;
      bus.RF_we = 1'b1; bus.Wr_sel = 3'd5; bus.Data_in = 8'h00;
      tick();
      bus.Pair_we = 1'b0; bus.RF_we = 1'b0;
      #1;
      chk("pair_out", bus.Pair_out, 16'hBEEF);
      rd_chk("pair_r5", 5, 8'hBE);
      rd_chk("pair_r6", 6, 8'hEF);

      // 4: load 10..17, save, clobber, restore
      for (int r = 0; r < 8; r++) begin
         bus.RF_we = 1'b1; bus.Wr_sel = 3'(r); bus.Data_in = 8'h10 + 8'(r);
         tick();
      end
      bus.RF_we = 1'b0;
      rd_chk("load_r3", 3, 8'h13);
      chk("load_pair", bus.Pair_out, 16'h1516);
      bus.Ctx_save = 1'b1;
      tick();
      bus.Ctx_save = 1'b0;
      busy_cnt = 0; done_cnt = 0; done_at = 0;
      for (int k = 1; k <= 20; k++) begin
         if (bus.Ctx_busy) busy_cnt++;
         if (bus.Ctx_done) begin
            done_cnt++;
            done_at = k;
         end
         tick();
      end
      chk("save_busy_cycles", 16'(busy_cnt), 16'd9);
      chk("save_done_cycle", 16'(done_at), 16'd9);
      chk("save_done_pulses", 16'(done_cnt), 16'd1);
      for (int r = 0; r < 8; r++) begin
         bus.RF_we = 1'b1; bus.Wr_sel = 3'(r); bus.Data_in = 8'hFF;
         tick();
      end
      bus.RF_we = 1'b0;
      rd_chk("clobber_r4", 4, 8'hFF);
      bus.Ctx_restore = 1'b1;
      tick();
      bus.Ctx_restore = 1'b0;
      repeat (10) tick();
      chk("restore_idle", {15'd0, bus.Ctx_busy}, 16'h0000);
      for (int r = 0; r < 8; r++) rd_chk("restore_rn", r, 8'h10 + 8'(r));
      chk("restore_acc", {8'h00, bus.Acc_out}, 16'h0010);
      chk("restore_pair", bus.Pair_out, 16'h1516);

      // 5: write blocked during save, then reset at idx 4
      bus.Ctx_save = 1'b1;
      tick();                       // now SAVE, idx 0
      bus.Ctx_save = 1'b0;
      bus.RF_we = 1'b1; bus.Wr_sel = 3'd3; bus.Data_in = 8'hAA;
      tick();                       // idx 1
      bus.RF_we = 1'b0;
      rd_chk("busy_wr_blocked", 3, 8'h13);
      chk("busy_mid_save", {15'd0, bus.Ctx_busy}, 16'h0001);
      repeat (3) tick();            // idx 4
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {15'd0, bus.Ctx_busy}, 16'h0000);
      chk("abort_done", {15'd0, bus.Ctx_done}, 16'h0000);
      chk("abort_acc", {8'h00, bus.Acc_out}, 16'h0049);
      rd_chk("abort_r3", 3, 8'h00);
      tick();
      rst_n = 1'b1;
      done_cnt = 0; busy_cnt = 0;
      for (int k = 0; k < 12; k++) begin
         if (bus.Ctx_done) done_cnt++;
         if (bus.Ctx_busy) busy_cnt++;
         tick();
      end
      chk("abort_no_done", 16'(done_cnt), 16'd0);
      chk("abort_no_busy", 16'(busy_cnt), 16'd0);
      // shadow bank was cleared by the reset: restoring yields all zeros
      bus.RF_we = 1'b1; bus.Wr_sel = 3'd1; bus.Data_in = 8'h77;
      tick();
      bus.RF_we = 1'b0;
      rd_chk("post_rst_wr", 1, 8'h77);
      bus.Ctx_restore = 1'b1;
      tick();
      bus.Ctx_restore = 1'b0;
      repeat (10) tick();
      rd_chk("shadow_cleared_r1", 1, 8'h00);
      chk("shadow_cleared_acc", {8'h00, bus.Acc_out}, 16'h0000);

      // 6: same-cycle read of a register being written
      bus.RF_we = 1'b1; bus.Wr_sel = 3'd4; bus.Data_in = 8'h5A;
      bus.Acc_we = 1'b1; bus.Acc_in = 8'h3C;
      bus.Rd_sel_a = 3'd4;
      #1;
`ifdef RF_BYPASS_EN
      chk("same_cycle_rd", {8'h00, bus.Data_out_a}, 16'h005A);
      chk("same_cycle_acc", {8'h00, bus.Acc_out}, 16'h003C);
`else
      chk("same_cycle_rd", {8'h00, bus.Data_out_a}, 16'h0000);
      chk("same_cycle_acc", {8'h00, bus.Acc_out}, 16'h0000);
`endif
      tick();
      bus.RF_we = 1'b0; bus.Acc_we = 1'b0;
      #1;
      chk("next_cycle_rd", {8'h00, bus.Data_out_a}, 16'h005A);
      chk("next_cycle_acc", {8'h00, bus.Acc_out}, 16'h003C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
